// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the packed-BCD to binary converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned MAX_DIGIT = 9;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_bin_mul10_add.sv
// One Horner step of the conversion: sum = acc*10 + digit, built from shifts and adds only.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [W-1:0]       sum
);

  assign sum = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional invalid-digit detection is enabled by defining BCD_CHECK_EN.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]          bin_d_out,
  output logic                      rdy,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned IN_W  = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t             state, state_nxt;
  logic [IN_W-1:0]    shreg, shreg_nxt;
  logic [BIN_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic               rdy_nxt;
  logic [DIGIT_W-1:0] digit;
  logic [BIN_W-1:0]   sum;
  logic               accept;
  logic               last;
  logic               final_bad;

  assign digit  = shreg[IN_W-1 -: DIGIT_W];
  assign accept = (state == IDLE) && en;
  assign last   = (state == CONV) && (cnt == LAST_CNT);
  assign busy   = (state == CONV);

  mul10_add #(.W(BIN_W)) u_mul10_add (
    .acc   (acc),
    .digit (digit),
    .sum   (sum)
  );

`ifdef BCD_CHECK_EN
  // Sticky flag collects bad digits as they stream past; the last digit is folded in combinationally.
  logic bad, bad_nxt;
  logic err_q, err_nxt;
  logic digit_bad;

  assign digit_bad = (digit > DIGIT_W'(MAX_DIGIT));
  assign final_bad = bad | digit_bad;
  assign err       = err_q;

  always_comb begin
    bad_nxt = bad;
    err_nxt = err_q;
    if (accept) begin
      bad_nxt = 1'b0;
    end else if (state == CONV) begin
      bad_nxt = final_bad;
      if (last) begin
        err_nxt = final_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad   <= bad_nxt;
      err_q <= err_nxt;
    end
  end
`else
  assign final_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    bin_nxt   = bin_d_out;
    rdy_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          shreg_nxt = bcd_d_in;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        acc_nxt   = sum;
        shreg_nxt = shreg << DIGIT_W;
        cnt_nxt   = cnt + CNT_W'(1);
        if (last) begin
          bin_nxt   = final_bad ? '0 : sum;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      bin_d_out <= '0;
      rdy       <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      bin_d_out <= bin_nxt;
      rdy       <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: the driver queues expected results, the monitor checks them on rdy.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [4*DIGITS-1:0] bcd_d_in;
  logic [BIN_W-1:0]   bin_d_out;
  logic               rdy;
  logic               busy;
  logic               err;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int unsigned      due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc    = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  logic [BIN_W-1:0] hold_bin = '0;
  logic             hold_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result becomes visible DIGITS edges after the sampling edge that follows this negedge.
  task automatic push(input logic [BIN_W-1:0] b, input logic e);
    exp_t x;
    x.bin = b;
    x.err = e;
    x.due = cyc + 1 + DIGITS;
    sbq.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge where rdy of this conversion is visible.
  task automatic conv(input logic [15:0] v, input logic [BIN_W-1:0] b, input logic e, input bit toggle);
    en       = 1'b1;
    bcd_d_in = v;
    push(b, e);
    @(negedge clk);
    en = 1'b0;
    if (toggle) bcd_d_in = ~v;
    chk("busy_during_conv", {31'd0, busy}, 32'd1);
    repeat (DIGITS) @(negedge clk);
    chk("busy_after_conv", {31'd0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      hold_bin = '0;
      hold_err = 1'b0;
    end else if (rdy) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdy: got rdy=1 bin=%0d, expected no result (cycle %0d)", bin_d_out, cyc);
      end else begin
        x = sbq.pop_front();
        chk("bin_d_out", {18'd0, bin_d_out}, {18'd0, x.bin});
        chk("err", {31'd0, err}, {31'd0, x.err});
        chk("rdy_cycle", cyc, x.due);
        hold_bin = x.bin;
        hold_err = x.err;
      end
    end else begin
      chk("hold_bin", {18'd0, bin_d_out}, {18'd0, hold_bin});
      chk("hold_err", {31'd0, err}, {31'd0, hold_err});
    end
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    bcd_d_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_bin", {18'd0, bin_d_out}, 32'd0);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    conv(16'h1234, 14'd1234, 1'b0, 1'b0);
    @(negedge clk);
    conv(16'h9999, 14'd9999, 1'b0, 1'b0);
    @(negedge clk);
    conv(16'h0000, 14'd0, 1'b0, 1'b0);
    @(negedge clk);
    conv(16'h0001, 14'd1, 1'b0, 1'b0);
    // back-to-back via the task: next en is driven in the rdy cycle
    conv(16'h0002, 14'd2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // en held high across two conversions; the mid-conversion input change is ignored
    en       = 1'b1;
    bcd_d_in = 16'h0042;
    push(14'd42, 1'b0);
    @(negedge clk);
    bcd_d_in = 16'h0777;
    repeat (DIGITS) @(negedge clk);
    push(14'd777, 1'b0);
    @(negedge clk);
    en = 1'b0;
    repeat (DIGITS) @(negedge clk);
    repeat (2) @(negedge clk);

    // single en pulse while busy must not start a second conversion
    en       = 1'b1;
    bcd_d_in = 16'h0055;
    push(14'd55, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en       = 1'b1;
    bcd_d_in = 16'h0999;
    @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);

    // reset two cycles into a conversion aborts it
    en       = 1'b1;
    bcd_d_in = 16'h5678;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_bin", {18'd0, bin_d_out}, 32'd0);
    chk("abort_rdy", {31'd0, rdy}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    conv(16'h0100, 14'd100, 1'b0, 1'b0);
    @(negedge clk);

`ifdef BCD_CHECK_EN
    conv(16'h12A4, 14'd0, 1'b1, 1'b0);
    @(negedge clk);
    conv(16'h0321, 14'd321, 1'b0, 1'b0);
`else
    conv(16'h12A4, 14'd1304, 1'b0, 1'b0);
`endif
    @(negedge clk);

    conv(16'h4321, 14'd4321, 1'b0, 1'b1);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d results pending, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
